// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches words over a req/ack handshake into an
// instruction register, and presents decoded fields until the datapath consumes them.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]           NOP_WORD   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  PCSrc,
  input  logic [31:0]           ImmExt,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [6:0]            op,
  output logic [2:0]            funct3,
  output logic                  funct7_5,
  output logic [4:0]            rd,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [31:0]           instr_count
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_sum;
  logic [31:0]           ir_q, ir_d;
  logic [31:0]           count_q, count_d;

  // IR bits not exposed as decoded fields.
  logic unused_ir;
  assign unused_ir = ^{ir_q[31], ir_q[29:25]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_WORD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    count_d     = count_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    pc_sum      = PCSrc ? pc_q + ImmExt[ADDR_WIDTH-1:0] : pc_q + ADDR_WIDTH'(4);

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          // Misaligned targets are truncated to a word boundary, never trapped.
          pc_d    = {pc_sum[ADDR_WIDTH-1:2], 2'b00};
          count_d = count_q + 32'd1;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_count = count_q;
  assign op          = ir_q[6:0];
  assign rd          = ir_q[11:7];
  assign funct3      = ir_q[14:12];
  assign rs1         = ir_q[19:15];
  assign rs2         = ir_q[24:20];
  assign funct7_5    = ir_q[30];

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the control unit. Holds the PC, requests instruction words from instruction memory over a req/ack handshake, and latches each word into an instruction register. It presents the decoded fields (op, funct3, funct7_5, register indices) to the control unit. On each consume it takes back the branch decision (PCSrc) and the extended immediate to form the next PC.

## Interface

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction-memory address
- RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned)
- NOP_WORD, 32'h00000013, instruction register reset value (addi x0,x0,0)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_WIDTH  fetch address, equal to pc
- imem_ack  in  1  memory has returned imem_rdata this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- instr_valid  out  1  instruction register holds an unconsumed instruction
- instr_ready  in  1  datapath executes the presented instruction this cycle
- PCSrc  in  1  branch taken, sampled only on the consume cycle
- ImmExt  in  32  sign-extended immediate, sampled only on the consume cycle
- pc  out  ADDR_WIDTH  address of the presented instruction
- op  out  7  IR[6:0]
- funct3  out  3  IR[14:12]
- funct7_5  out  1  IR[30]
- rd  out  5  IR[11:7]
- rs1  out  5  IR[19:15]
- rs2  out  5  IR[24:20]
- instr_count  out  32  number of instructions consumed since reset

## Operation

- FSM states: IDLE, FETCH, HOLD.
- Reset (async, immediate): state=IDLE, pc=RESET_PC, IR=NOP_WORD, instr_count=0. Outputs during reset: imem_req=0, instr_valid=0, imem_addr=RESET_PC, op=7'b0010011, funct3=0, funct7_5=0, rd=rs1=rs2=0.
- IDLE: unconditionally moves to FETCH on the first clock edge after rst deasserts.
- FETCH: imem_req=1 and imem_addr=pc.
  - If imem_ack=1, IR<=imem_rdata and the state moves to HOLD.
  - Otherwise the state remains FETCH, with the address held stable.
- HOLD: instr_valid=1 and imem_req=0.
  - If instr_ready=1 (consume):
    - pc <= PCSrc ? pc + ImmExt[ADDR_WIDTH-1:0] : pc + 4
    - instr_count <= instr_count + 1
    - state moves to FETCH.
  - Otherwise everything holds.
- Field outputs are decoded combinationally from IR.
- IR changes only on an accepted ack in FETCH.
- imem_ack is ignored in IDLE and HOLD. A stray ack does not modify IR.
- PCSrc and ImmExt are ignored in every cycle other than the consume cycle.
- instr_ready is ignored outside HOLD.
- Next-PC arithmetic is modulo 2^ADDR_WIDTH: wrap-around from the top of the address space is silent.
- Next-PC bits [1:0] are forced to 00. A misaligned branch target is truncated, not trapped.
- instr_count wraps from 0xFFFFFFFF to 0.
- Reset asserted mid-fetch or mid-hold abandons the transaction. A later ack for the abandoned request, arriving while in IDLE, is ignored.

## Timing

- Zero-wait memory (ack in the first FETCH cycle): IR is loaded at the end of that cycle, and instr_valid=1 in the next cycle.
- Minimum throughput is 2 cycles per instruction (FETCH, HOLD) with ack and ready both immediate.
- imem_req rises in the first cycle after the IDLE cycle, i.e. 1 cycle after reset release.
- In FETCH, imem_addr is stable from the rise of imem_req until the ack cycle inclusive.
- instr_valid and the field outputs are stable throughout HOLD until the consume edge.
- pc updates on the consume edge. imem_addr shows the new pc in the following FETCH cycle.
- No combinational path from imem_ack or instr_ready to imem_req or instr_valid: both are pure functions of state.

## Test plan

- Reset then zero-wait memory returning 0x00500093 at address 0, instr_ready=1, PCSrc=0:
  - imem_req=1 one cycle after release, with imem_addr=0
  - next cycle instr_valid=1, op=0x13, rd=1, rs1=0
  - after consume, imem_addr=4 and instr_count=1
- Memory with 3-cycle ack latency:
  - imem_req stays high and imem_addr constant for all 3 cycles
  - IR is loaded only on the ack cycle
  - stray ack pulses during HOLD leave the fields unchanged
- Branch at pc=0x20 with PCSrc=1:
  - ImmExt=0xFFFFFFF0 → next imem_addr=0x10
  - ImmExt=0x6 → next imem_addr=0x24 (low bits cleared)
- Backpressure: instr_ready held 0 for 5 cycles in HOLD → instr_valid, pc and fields hold, imem_req=0, instr_count unchanged; then ready=1 → single increment.
- Wrap: pc=0xFFFFFFFC, PCSrc=0 consume → next imem_addr=0x00000000.
- Async reset asserted in FETCH before ack:
  - imem_req and instr_valid drop immediately, pc=RESET_PC, op=0x13, instr_count=0
  - an ack arriving while in IDLE is ignored.
